// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage behind the datapath. It runs word and
//               byte loads and stores against a synchronous data RAM, and
//               returns load results through the register-file load port.
//               Byte stores are done as a read-modify-write of the whole word.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int RD_LATENCY = 1,   // cycles from sampled read to valid data, 1..4
    parameter int ADDR_W     = 11   // RAM word-address width
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_byte,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       str_data,
    input  logic [3:0]        rd_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       w_data_ldr,
    output logic [3:0]        w_addr_ldr,
    output logic              w_en_ldr,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LD_WAIT  = 3'd1;
    localparam logic [2:0] S_LD_WB    = 3'd2;
    localparam logic [2:0] S_ST_WR    = 3'd3;
    localparam logic [2:0] S_RMW_WAIT = 3'd4;
    localparam logic [2:0] S_RMW_WR   = 3'd5;

    // Wait-counter value at which read data is valid on mem_rdata.
    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    logic [2:0]        state_q,      state_d;
    logic [2:0]        cnt_q,        cnt_d;
    logic [1:0]        lane_q,       lane_d;
    logic              is_byte_q,    is_byte_d;
    logic [7:0]        st_byte_q,    st_byte_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic              mem_rden_q,   mem_rden_d;
    logic              mem_wren_q,   mem_wren_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic [31:0]       w_data_q,     w_data_d;
    logic [3:0]        w_addr_q,     w_addr_d;
    logic              w_en_q,       w_en_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;

    // Lane extracted from the read word, and the read word with the store
    // byte merged into the selected lane.
    logic [7:0]        w_lane_byte;
    logic [31:0]       w_merged;

    // Address bits above the RAM range are deliberately ignored so accesses
    // wrap inside the RAM.
    logic              w_unused_addr;
    assign w_unused_addr = ^addr_in[31:ADDR_W+2];

    // Select the addressed little-endian lane of the returned RAM word.
    always_comb begin
        w_lane_byte = mem_rdata[7:0];
        case (lane_q)
            2'd0:    w_lane_byte = mem_rdata[7:0];
            2'd1:    w_lane_byte = mem_rdata[15:8];
            2'd2:    w_lane_byte = mem_rdata[23:16];
            2'd3:    w_lane_byte = mem_rdata[31:24];
            default: w_lane_byte = mem_rdata[7:0];
        endcase
    end

    // Replace the addressed lane of the returned RAM word with the store byte.
    always_comb begin
        w_merged = mem_rdata;
        case (lane_q)
            2'd0:    w_merged[7:0]   = st_byte_q;
            2'd1:    w_merged[15:8]  = st_byte_q;
            2'd2:    w_merged[23:16] = st_byte_q;
            2'd3:    w_merged[31:24] = st_byte_q;
            default: w_merged[7:0]   = st_byte_q;
        endcase
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_d      = lane_q;
        is_byte_d   = is_byte_q;
        st_byte_d   = st_byte_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        w_data_d    = w_data_q;
        w_addr_d    = w_addr_q;
        busy_d      = busy_q;
        // Strobes are single-cycle unless a state raises them.
        mem_rden_d  = 1'b0;
        mem_wren_d  = 1'b0;
        w_en_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Latch the request; everything afterwards uses the copies.
                    mem_addr_d = addr_in[ADDR_W+1:2];
                    lane_d     = addr_in[1:0];
                    is_byte_d  = is_byte;
                    st_byte_d  = str_data[7:0];
                    cnt_d      = 3'd0;
                    busy_d     = 1'b1;
                    if (is_load) begin
                        state_d    = S_LD_WAIT;
                        mem_rden_d = 1'b1;
                        w_addr_d   = rd_addr;
                    end else if (!is_byte) begin
                        state_d     = S_ST_WR;
                        mem_wren_d  = 1'b1;
                        done_d      = 1'b1;
                        mem_wdata_d = str_data;
                    end else begin
                        state_d    = S_RMW_WAIT;
                        mem_rden_d = 1'b1;
                    end
                end
            end

            // The read strobe is issued once on accept; this state only waits
            // for the RAM pipeline to deliver the word, then captures it.
            S_LD_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d  = S_LD_WB;
                    w_en_d   = 1'b1;
                    done_d   = 1'b1;
                    w_data_d = is_byte_q ? {24'd0, w_lane_byte} : mem_rdata;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            S_RMW_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d     = S_RMW_WR;
                    mem_wren_d  = 1'b1;
                    done_d      = 1'b1;
                    mem_wdata_d = w_merged;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            // Terminal cycles: the strobe raised on entry drops here.
            S_LD_WB, S_ST_WR, S_RMW_WR: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Register all state and outputs; reset clears every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            lane_q      <= 2'd0;
            is_byte_q   <= 1'b0;
            st_byte_q   <= 8'd0;
            mem_addr_q  <= '0;
            mem_rden_q  <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_wdata_q <= 32'd0;
            w_data_q    <= 32'd0;
            w_addr_q    <= 4'd0;
            w_en_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            is_byte_q   <= is_byte_d;
            st_byte_q   <= st_byte_d;
            mem_addr_q  <= mem_addr_d;
            mem_rden_q  <= mem_rden_d;
            mem_wren_q  <= mem_wren_d;
            mem_wdata_q <= mem_wdata_d;
            w_data_q    <= w_data_d;
            w_addr_q    <= w_addr_d;
            w_en_q      <= w_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rden   = mem_rden_q;
    assign mem_wren   = mem_wren_q;
    assign mem_wdata  = mem_wdata_q;
    assign w_data_ldr = w_data_q;
    assign w_addr_ldr = w_addr_q;
    assign w_en_ldr   = w_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Two instances run
//               the same request stream, one with RD_LATENCY=1 and one with
//               RD_LATENCY=3, each against its own RAM model. Expected
//               accesses are queued when a request is driven and compared
//               when the instance produces its write-back or RAM write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    typedef struct {
        bit          is_ld;
        bit          byt;
        logic [10:0] addr;
        logic [31:0] data;
        logic [3:0]  rd;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        is_load;
    logic        is_byte;
    logic [31:0] addr_in;
    logic [31:0] str_data;
    logic [3:0]  rd_addr;

    logic [10:0] addr1, addr3;
    logic        rden1, rden3, wren1, wren3;
    logic [31:0] wdata1, wdata3, rdata1, rdata3, wdl1, wdl3;
    logic [3:0]  wal1, wal3;
    logic        wen1, wen3, busy1, busy3, done1, done3;

    load_store_unit #(.RD_LATENCY(1), .ADDR_W(11)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
        .is_byte(is_byte), .addr_in(addr_in), .str_data(str_data),
        .rd_addr(rd_addr), .mem_addr(addr1), .mem_rden(rden1),
        .mem_wren(wren1), .mem_wdata(wdata1), .mem_rdata(rdata1),
        .w_data_ldr(wdl1), .w_addr_ldr(wal1), .w_en_ldr(wen1),
        .busy(busy1), .done(done1)
    );

    load_store_unit #(.RD_LATENCY(3), .ADDR_W(11)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
        .is_byte(is_byte), .addr_in(addr_in), .str_data(str_data),
        .rd_addr(rd_addr), .mem_addr(addr3), .mem_rden(rden3),
        .mem_wren(wren3), .mem_wdata(wdata3), .mem_rdata(rdata3),
        .w_data_ldr(wdl3), .w_addr_ldr(wal3), .w_en_ldr(wen3),
        .busy(busy3), .done(done3)
    );

    // ------------------------------------------------------------------------
    // RAM models: read data is X except in the one cycle it is valid.
    // ------------------------------------------------------------------------
    logic [31:0] ram1 [0:2047];
    logic [31:0] ram3 [0:2047];
    logic [31:0] mdl  [0:2047];
    logic [31:0] p3a, p3b;
    logic        ram_init;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        if (i == 2) return 32'hAABBCCDD;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00A5;
    endfunction

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 2048; i++) begin
                ram1[i] <= init_word(i);
                ram3[i] <= init_word(i);
            end
        end
        rdata1 <= rden1 ? ram1[addr1] : 'x;
        if (wren1) ram1[addr1] <= wdata1;
        p3a    <= rden3 ? ram3[addr3] : 'x;
        p3b    <= p3a;
        rdata3 <= p3b;
        if (wren3) ram3[addr3] <= wdata3;
    end

    // ------------------------------------------------------------------------
    // Cycle counter and per-instance activity counters
    // ------------------------------------------------------------------------
    int cyc = 0;
    int bc1 = 0, bc3 = 0, rc1 = 0, rc3 = 0, wc1 = 0, wc3 = 0, xc1 = 0, xc3 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bc1 <= bc1 + int'(busy1);
        bc3 <= bc3 + int'(busy3);
        rc1 <= rc1 + int'(rden1);
        rc3 <= rc3 + int'(rden3);
        wc1 <= wc1 + int'(wren1);
        wc3 <= wc3 + int'(wren3);
        xc1 <= xc1 + int'(rden1 & wren1);
        xc3 <= xc3 + int'(rden3 & wren3);
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string p, input int lat, input exp_t e,
                          input logic wen, input logic wren, input logic dn,
                          input logic [10:0] ma, input logic [31:0] wd,
                          input logic [31:0] wdl, input logic [3:0] wal);
        int want_cyc;
        want_cyc = e.acc + ((e.is_ld || e.byt) ? lat + 1 : 0);
        check({p, "_kind"},  {62'd0, wen, wren}, e.is_ld ? 64'd2 : 64'd1);
        check({p, "_done"},  64'(dn), 64'd1);
        check({p, "_addr"},  64'(ma), 64'(e.addr));
        check({p, "_cycle"}, 64'(cyc), 64'(want_cyc));
        if (e.is_ld) begin
            check({p, "_ld_data"}, 64'(wdl), 64'(e.data));
            check({p, "_ld_reg"},  64'(wal), 64'(e.rd));
        end else begin
            check({p, "_st_data"}, 64'(wd), 64'(e.data));
        end
    endtask

    exp_t q1[$];
    exp_t q3[$];

    always @(negedge clk) begin
        if (rst_n && (wen1 || wren1)) begin
            if (q1.size() == 0) check("d1_unexpected_access", {62'd0, wen1, wren1}, 64'd0);
            else chk_ev("d1", 1, q1.pop_front(), wen1, wren1, done1, addr1, wdata1, wdl1, wal1);
        end
    end

    always @(negedge clk) begin
        if (rst_n && (wen3 || wren3)) begin
            if (q3.size() == 0) check("d3_unexpected_access", {62'd0, wen3, wren3}, 64'd0);
            else chk_ev("d3", 3, q3.pop_front(), wen3, wren3, done3, addr3, wdata3, wdl3, wal3);
        end
    end

    // ------------------------------------------------------------------------
    // One request: queue expectations, pulse start, scramble inputs after
    // accept, optionally poke a store while busy, then check cycle counts.
    // ------------------------------------------------------------------------
    task automatic do_op(input bit ld, input bit byt, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] rd, input bit poke);
        exp_t        e;
        logic [10:0] w;
        logic [31:0] m;
        int          lane, k;
        int          b1, b3, r1, r3, s1, s3, x1, x3;
        bit          rd_op;
        w     = a[12:2];
        lane  = int'(a[1:0]);
        rd_op = ld || byt;
        e.is_ld = ld;
        e.byt   = byt;
        e.addr  = w;
        e.rd    = ld ? rd : 4'd0;
        e.acc   = cyc + 1;
        m = mdl[w];
        if (ld) begin
            e.data = byt ? {24'd0, m[8*lane +: 8]} : m;
        end else begin
            if (byt) m[8*lane +: 8] = d[7:0];
            else     m = d;
            e.data = m;
            mdl[w] = m;
        end
        q1.push_back(e);
        q3.push_back(e);
        b1 = bc1; b3 = bc3; r1 = rc1; r3 = rc3;
        s1 = wc1; s3 = wc3; x1 = xc1; x3 = xc3;

        start = 1'b1; is_load = ld; is_byte = byt;
        addr_in = a; str_data = d; rd_addr = rd;
        @(negedge clk);
        start = 1'b0; is_load = ~ld; is_byte = ~byt;
        addr_in = $urandom; str_data = $urandom; rd_addr = 4'($urandom);
        if (poke) begin
            @(negedge clk);
            start = 1'b1; is_load = 1'b0; is_byte = 1'b0;
            addr_in = a; str_data = 32'd0;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while ((busy1 || busy3) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("op_finished_in_time", {62'd0, busy1, busy3}, 64'd0);
        @(negedge clk);
        check("d1_busy_cycles", 64'(bc1 - b1), rd_op ? 64'd3 : 64'd1);
        check("d3_busy_cycles", 64'(bc3 - b3), rd_op ? 64'd5 : 64'd1);
        check("d1_rd_wr_overlap_counts", {16'(rc1 - r1), 16'(wc1 - s1), 32'(xc1 - x1)},
              {16'(rd_op ? 1 : 0), 16'(ld ? 0 : 1), 32'd0});
        check("d3_rd_wr_overlap_counts", {16'(rc3 - r3), 16'(wc3 - s3), 32'(xc3 - x3)},
              {16'(rd_op ? 1 : 0), 16'(ld ? 0 : 1), 32'd0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int nbad;
        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; is_byte = 1'b0;
        addr_in = 32'd0; str_data = 32'd0; rd_addr = 4'd0;
        ram_init = 1'b1;
        for (int i = 0; i < 2048; i++) mdl[i] = init_word(i);
        @(posedge clk);
        @(posedge clk);
        ram_init = 1'b0;
        @(negedge clk);
        check("d1_reset_ctrl", {44'd0, addr1, wal1, rden1, wren1, wen1, busy1, done1}, 64'd0);
        check("d1_reset_data", {wdata1, wdl1}, 64'd0);
        check("d3_reset_ctrl", {44'd0, addr3, wal3, rden3, wren3, wen3, busy3, done3}, 64'd0);
        check("d3_reset_data", {wdata3, wdl3}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word load of RAM[5] into r3.
        do_op(1'b1, 1'b0, 32'h14, 32'd0, 4'd3, 1'b0);
        // Byte loads of each lane of the same word.
        for (int i = 0; i < 4; i++) do_op(1'b1, 1'b1, 32'h14 + 32'(i), 32'd0, 4'(i + 1), 1'b0);
        // Unaligned word store lands on word 8 unrotated.
        do_op(1'b0, 1'b0, 32'h23, 32'h12345678, 4'd0, 1'b0);
        check("word_store_ram", {ram1[8], ram3[8]}, {2{32'h12345678}});
        // Byte store into lane 2 of RAM[2]; only str_data[7:0] is used.
        do_op(1'b0, 1'b1, 32'h0A, 32'hFFFFFF11, 4'd0, 1'b0);
        check("rmw_ram", {ram1[2], ram3[2]}, {2{32'hAA11CCDD}});
        // Remaining lanes, then read the merged word back.
        do_op(1'b0, 1'b1, 32'h0B, 32'h00000077, 4'd0, 1'b0);
        do_op(1'b0, 1'b1, 32'h08, 32'h00000022, 4'd0, 1'b0);
        do_op(1'b1, 1'b0, 32'h08, 32'd0, 4'd6, 1'b0);
        check("rmw_lanes_ram", {ram1[2], ram3[2]}, {2{32'h7711CC22}});
        // High address bits wrap into the RAM.
        do_op(1'b1, 1'b0, 32'h8000_0014, 32'd0, 4'hF, 1'b0);
        // A store strobe while busy must be ignored.
        do_op(1'b1, 1'b0, 32'h14, 32'd0, 4'd7, 1'b1);
        check("poke_ram_unchanged", {ram1[5], ram3[5]}, {2{32'hDEADBEEF}});

        // Reset asserted during RMW_WAIT aborts the byte store.
        start = 1'b1; is_load = 1'b0; is_byte = 1'b1;
        addr_in = 32'h29; str_data = 32'h55; rd_addr = 4'd0;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("d1_async_reset_ctrl", {44'd0, addr1, wal1, rden1, wren1, wen1, busy1, done1}, 64'd0);
        check("d1_async_reset_data", {wdata1, wdl1}, 64'd0);
        check("d3_async_reset_ctrl", {44'd0, addr3, wal3, rden3, wren3, wen3, busy3, done3}, 64'd0);
        check("d3_async_reset_data", {wdata3, wdl3}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_abort_ram", {ram1[10], ram3[10]}, {2{mdl[10]}});
        do_op(1'b1, 1'b0, 32'h28, 32'd0, 4'd9, 1'b0);

        // Final state.
        check("d1_queue_drained", 64'(q1.size()), 64'd0);
        check("d3_queue_drained", 64'(q3.size()), 64'd0);
        nbad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (ram1[i] !== mdl[i]) nbad++;
            if (ram3[i] !== mdl[i]) nbad++;
        end
        check("ram_contents_vs_model", 64'(nbad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of `datapath`. It takes the effective address (`datapath_out`) and store data (`str_data`) of an LDR/STR/LDRB/STRB instruction and runs the access against the synchronous data RAM. Loaded values go back to the register file through the dedicated load write port (`w_data_ldr`/`w_addr_ldr`/`w_en_ldr`). Byte stores are done as read-modify-write of the containing word.

## Interface
Parameters:
- `RD_LATENCY`, default 1: cycles from RAM address/read-enable sampled to `mem_rdata` valid; legal 1..4.
- `ADDR_W`, default 11: RAM word-address width.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request strobe, sampled only in IDLE
- `is_load`  in  1  1 = LDR/LDRB, 0 = STR/STRB
- `is_byte`  in  1  1 = byte access, 0 = word access
- `addr_in`  in  32  effective byte address (from `datapath_out`)
- `str_data`  in  32  store data (from datapath `str_data`)
- `rd_addr`  in  4  load destination register
- `mem_addr`  out  ADDR_W  RAM word address
- `mem_rden`  out  1  RAM read enable
- `mem_wren`  out  1  RAM write enable
- `mem_wdata`  out  32  RAM write data
- `mem_rdata`  in  32  RAM read data
- `w_data_ldr`  out  32  load result to regfile
- `w_addr_ldr`  out  4  load destination to regfile
- `w_en_ldr`  out  1  regfile load write strobe, one cycle
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- Word index is `addr_in[ADDR_W+1:2]`. Lane is `addr_in[1:0]`, little-endian: lane 0 is bits 7:0.
- Word accesses ignore `addr_in[1:0]`: address is forced to alignment, no rotation.
- On accept, `addr_in`, `str_data`, `rd_addr`, `is_load` and `is_byte` are latched. All later behaviour uses only the latched copies.
- States:
  - IDLE: `start`=1 → LD_WAIT if `is_load`; ST_WR if word store; RMW_WAIT if byte store.
  - LD_WAIT: `mem_rden`=1; counts `RD_LATENCY` cycles, then goes to LD_WB.
  - LD_WB: `w_en_ldr`=1 and `done`=1 for one cycle. `w_data_ldr` is the word, or the byte zero-extended to 32 bits. Then IDLE.
  - ST_WR: `mem_wren`=1, `done`=1 for one cycle, `mem_wdata` = latched `str_data`. Then IDLE.
  - RMW_WAIT: `mem_rden`=1; counts `RD_LATENCY`, then captures `mem_rdata` and replaces the selected lane with `str_data[7:0]`.
  - RMW_WR: `mem_wren`=1 with the merged word, `done`=1. Then IDLE.
- `start` outside IDLE is ignored and not queued. The caller must hold the instruction until `busy` falls.
- `mem_rden` and `mem_wren` are never high in the same cycle.
- `w_addr_ldr` = latched `rd_addr`. `w_en_ldr` is never high on a store.

## Timing
- All outputs are registered.
- Reset values: `mem_addr`=0, `mem_rden`=0, `mem_wren`=0, `mem_wdata`=0, `w_data_ldr`=0, `w_addr_ldr`=0, `w_en_ldr`=0, `busy`=0, `done`=0; state = IDLE.
- Let E0 be the edge that accepts `start`. With L = `RD_LATENCY`:
  - Load: `mem_addr` and `mem_rden` are valid from E0. `mem_rdata` is valid in the cycle after edge E(L). Data is captured at E(L+1). `w_en_ldr`/`done` are high from E(L+1) to E(L+2). `busy` is high from E0 to E(L+2). Total: L+2 cycles.
  - Word store: `mem_wren`/`done` high from E0 to E1. `busy` high for 1 cycle.
  - Byte store: read is the same as for a load. `mem_wren`/`done` are high from E(L+1) to E(L+2). Total: L+2 cycles.
- Back-to-back: a `start` sampled at the edge where `busy` falls (returns to IDLE) is accepted at the next edge, so there is at least one idle cycle between operations.
- `rst_n` asserted mid-operation drops `mem_wren`/`mem_rden`/`w_en_ldr` immediately. No partial RMW write occurs after reset asserts.
- `addr_in` bits above `ADDR_W+1` are ignored; the address wraps within RAM.

## Test plan
- Word load, L=1: RAM[5]=0xDEADBEEF, `start`, `is_load`=1, `addr_in`=0x14, `rd_addr`=3 → `mem_addr`=5, `mem_rden` for 1 cycle; `w_en_ldr`=1 with `w_data_ldr`=0xDEADBEEF, `w_addr_ldr`=3 exactly 2 cycles after the accept edge; `done` coincident.
- Byte loads: same word, `addr_in`=0x14..0x17 → `w_data_ldr` = 0xEF, 0xBE, 0xAD, 0xDE, each zero-extended.
- Word store: `addr_in`=0x23 (unaligned), `str_data`=0x12345678 → `mem_addr`=8, `mem_wren` for exactly 1 cycle, `mem_wdata`=0x12345678, `w_en_ldr` never high.
- Byte store RMW, L=3: RAM[2]=0xAABBCCDD, `addr_in`=0x0A, `str_data`=0x11 → one read, then write of 0xAA11CCDD 4 cycles after accept; `busy` high for 5 cycles.
- `start` pulsed while busy (during LD_WAIT) → ignored: no second access, RAM unchanged, single `done`.
- `rst_n` low during RMW_WAIT → all outputs 0 asynchronously, no `mem_wren`, RAM word unchanged; after release, a word load completes normally.
